seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Inverse of the BCD-to-7-segment encoder. Monitors the active-low anode/segment bus of a multiplexed
//  multi-digit display and reconstructs the BCD digits being shown, with per-digit blank/error flags.
//  Sits beside the display driver as a self-check/loopback observer; its outputs feed test logic or LEDs.
// PARAMETERS
//  NUM_DIGITS     4        number of anodes scanned
//  SETTLE_CYCLES  16       consecutive stable cycles required before a slot is sampled (>=2)
//  TIMEOUT_CYCLES 1000000  cycles without any capture before stale asserts
// PORTS
//  clk          in   1             system clock, all logic on rising edge
//  reset        in   1             synchronous, active-high reset
//  an_n         in   NUM_DIGITS    anode enables, active-low, one-hot-low when valid; bit i = digit i
//  seg_n        in   7             segments, active-low, ABCDEFG order, A = seg_n[6]
//  digits_bcd   out  4*NUM_DIGITS  digit i in [4*i+3:4*i]
//  digit_blank  out  NUM_DIGITS    1 = digit i showed all-off (7'b1111111)
//  digit_err    out  NUM_DIGITS    1 = digit i showed a pattern outside the 0-9/blank table
//  frame_valid  out  1             one-cycle pulse when a complete new frame is published
//  stale        out  1             no capture for TIMEOUT_CYCLES
// BEHAVIOUR
//  - Reset: digits_bcd=0, digit_blank=all 1, digit_err=0, frame_valid=0, stale=0; FSM IDLE; seen mask,
//    settle/timeout counters and shadow regs cleared. Reset mid-frame discards partial frame.
//  - an_n/seg_n pass a 2-flop synchronizer; all timing below is from synchronized values.
//  - Decode table (seg_n -> value): 0000001=0 1001111=1 0010010=2 0000110=3 1001100=4 0100100=5
//    0100000=6 0001111=7 0000000=8 0000100=9; 1111111=blank (bcd 0); anything else=err (bcd 0).
//  - FSM: IDLE: an_n not exactly one bit low -> stay; valid one-hot -> SETTLE, count=1.
//    SETTLE: {an_n,seg_n} unchanged -> count++; any change -> restart count=1 (IDLE if an_n invalid);
//    count==SETTLE_CYCLES -> capture, -> HOLD. HOLD: stay while unchanged (no re-capture);
//    any change -> SETTLE (count=1) or IDLE if invalid.
//  - Capture: shadow[i] <= decoded value/blank/err for the low anode i; seen[i] <= 1; timeout count <= 0.
//    Re-capture of an already-seen digit in the same frame overwrites shadow (last wins).
//  - Publish: cycle after seen==all ones, outputs <= shadow, frame_valid=1 for exactly that cycle,
//    seen <= 0. If a capture lands on the publish cycle, clear then set its bit (new capture kept).
//  - Latency: pin change to capture = 2 + SETTLE_CYCLES cycles; last capture to frame_valid = 1 cycle.
//  - Outputs hold last published frame between frames; never partially updated.
//  - stale: set when timeout count reaches TIMEOUT_CYCLES (saturates); cleared on next frame_valid.
//  - Counters saturate; no wrap. Multiple anodes low (ghosting) treated as invalid -> IDLE, no capture.
// STRUCTURE
//  - Shared package seg7_pkg: SEG_0..SEG_9, SEG_BLANK 7-bit active-low constants (shared with the
//    encoder), FSM state encoding (IDLE/SETTLE/HOLD), decode result struct {bcd,blank,err}.
//  - Sub-module seg7_pattern_decode: combinational seg_n -> {bcd[3:0],blank,err}.
//  - Top: synchronizer, FSM + settle counter, one-hot-to-index, shadow regs, seen mask, publish, timeout.
// TESTING
//  - Scan 1,2,3,4 (an_n=1110 seg 1001111, 1101/0010010, 1011/0000110, 0111/1001100), 20 cycles each
//    -> one frame_valid, digits_bcd=16'h4321, blank=0, err=0.
//  - Slot held only SETTLE_CYCLES-1 stable cycles then changed -> no capture, no frame_valid.
//  - digit2 seg_n=1111111, digit3 seg_n=1110000 -> digit_blank=4'b0100, digit_err=4'b1000, bcd nibbles 0.
//  - an_n=1100 for 100 cycles mid-scan -> no capture; frame completes only after valid slots resume.
//  - Reset asserted after 2 of 4 digits captured -> outputs at reset values, next frame needs all 4.
//  - Bus frozen at an_n=1111 for TIMEOUT_CYCLES -> stale=1; a full valid scan -> frame_valid, stale=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment encoder/decoder pair.
//   SEG_0..SEG_9, SEG_BLANK : active-low segment patterns, ABCDEFG order, A = bit 6
//   scan_state_e            : anode scan tracker states
//   seg_decode_t            : decoded pattern {bcd, blank, err}
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [3:0] bcd;
    logic       blank;
    logic       err;
  } seg_decode_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the BCD-to-7-segment encoder.
//   seg_n  in  7  active-low segment pattern, A = seg_n[6]
//   result out    {bcd, blank, err}; bcd is 0 for blank and for unknown patterns
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0]  seg_n,
  output seg_decode_t result
);

  always_comb begin
    result = '0;
    case (seg_n)
      SEG_0:     result.bcd = 4'd0;
      SEG_1:     result.bcd = 4'd1;
      SEG_2:     result.bcd = 4'd2;
      SEG_3:     result.bcd = 4'd3;
      SEG_4:     result.bcd = 4'd4;
      SEG_5:     result.bcd = 4'd5;
      SEG_6:     result.bcd = 4'd6;
      SEG_7:     result.bcd = 4'd7;
      SEG_8:     result.bcd = 4'd8;
      SEG_9:     result.bcd = 4'd9;
      SEG_BLANK: result.blank = 1'b1;
      default:   result.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Loopback observer for a multiplexed active-low 7-segment display. Watches the
// anode/segment bus, captures each digit once its slot has been stable long
// enough, and publishes a whole frame once every digit has been seen.
//   clk, reset     system clock; synchronous active-high reset
//   an_n           anode enables, active-low, one-hot-low when valid
//   seg_n          segments, active-low, A = seg_n[6]
//   digits_bcd     digit i in [4*i+3:4*i] of the last published frame
//   digit_blank    digit i showed all segments off
//   digit_err      digit i showed a pattern outside the 0-9/blank table
//   frame_valid    one-cycle pulse when a new frame is published
//   stale          no capture for TIMEOUT_CYCLES; cleared by the next frame
//
// state     | meaning
// ST_IDLE   | anode bus not one-hot-low, waiting for a valid slot
// ST_SETTLE | valid slot seen, counting stable cycles before capture
// ST_HOLD   | slot captured, ignoring it until the bus changes
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg_n,
  output logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    stale
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // settle counter counts down the remaining stable cycles; zero means the
  // slot has been stable for SETTLE_CYCLES cycles
  localparam logic [SW-1:0] SETTLE_LOAD  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES);

  logic [NUM_DIGITS-1:0] an_s1, an_s2, an_prev;
  logic [6:0]            seg_s1, seg_s2, seg_prev;

  scan_state_e           state, state_nxt;
  logic [SW-1:0]         settle_cnt, settle_nxt;
  logic [TW-1:0]         tmo_cnt;

  logic [NUM_DIGITS-1:0] an_low;
  logic                  an_valid;
  logic [IW-1:0]         an_idx;
  logic                  bus_changed;
  logic                  capture;
  logic                  publish;
  seg_decode_t           seg_dec;

  logic [NUM_DIGITS-1:0]       seen;
  logic [NUM_DIGITS-1:0][3:0]  shadow_bcd;
  logic [NUM_DIGITS-1:0]       shadow_blank;
  logic [NUM_DIGITS-1:0]       shadow_err;

  // two-flop synchronizer plus one more stage to detect bus changes
  always_ff @(posedge clk) begin
    if (reset) begin
      an_s1    <= '1;
      an_s2    <= '1;
      an_prev  <= '1;
      seg_s1   <= SEG_BLANK;
      seg_s2   <= SEG_BLANK;
      seg_prev <= SEG_BLANK;
    end else begin
      an_s1    <= an_n;
      an_s2    <= an_s1;
      an_prev  <= an_s2;
      seg_s1   <= seg_n;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
    end
  end

  assign an_low      = ~an_s2;
  assign an_valid    = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
  assign bus_changed = (an_s2 != an_prev) || (seg_s2 != seg_prev);
  assign publish     = &seen;

  always_comb begin
    an_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) an_idx = IW'(i);
    end
  end

  seg7_pattern_decode u_pattern_decode (
    .seg_n  (seg_s2),
    .result (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (an_valid) begin
          state_nxt  = ST_SETTLE;
          settle_nxt = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (bus_changed) begin
          if (an_valid) settle_nxt = SETTLE_LOAD;
          else          state_nxt  = ST_IDLE;
        end else if (settle_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end else begin
          settle_nxt = settle_cnt - SW'(1);
        end
      end
      ST_HOLD: begin
        if (bus_changed) begin
          if (an_valid) begin
            state_nxt  = ST_SETTLE;
            settle_nxt = SETTLE_LOAD;
          end else begin
            state_nxt  = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen         <= '0;
      shadow_bcd   <= '0;
      shadow_blank <= '0;
      shadow_err   <= '0;
      digits_bcd   <= '0;
      digit_blank  <= '1;
      digit_err    <= '0;
      frame_valid  <= 1'b0;
      stale        <= 1'b0;
      tmo_cnt      <= TIMEOUT_LOAD;
    end else begin
      frame_valid <= publish;
      if (publish) begin
        digits_bcd  <= shadow_bcd;
        digit_blank <= shadow_blank;
        digit_err   <= shadow_err;
      end
      // a capture on the publish cycle starts the next frame
      seen <= (publish ? '0 : seen) | (capture ? an_low : '0);
      if (capture) begin
        shadow_bcd[an_idx]   <= seg_dec.bcd;
        shadow_blank[an_idx] <= seg_dec.blank;
        shadow_err[an_idx]   <= seg_dec.err;
      end
      if (capture)              tmo_cnt <= TIMEOUT_LOAD;
      else if (tmo_cnt != '0)   tmo_cnt <= tmo_cnt - TW'(1);
      if (publish)              stale <= 1'b0;
      else if (tmo_cnt == '0)   stale <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int S  = 16;
  localparam int T  = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  an_n = 4'hf;
  logic [6:0]  seg_n = 7'h7f;
  logic [15:0] digits_bcd;
  logic [3:0]  digit_blank, digit_err;
  logic        frame_valid, stale;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .an_n(an_n), .seg_n(seg_n),
    .digits_bcd(digits_bcd), .digit_blank(digit_blank), .digit_err(digit_err),
    .frame_valid(frame_valid), .stale(stale)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_fv_cyc = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic [3:0]  err;
  } frame_t;

  frame_t obs_q[$];
  frame_t exp_q[$];

  always @(negedge clk) begin
    if (frame_valid) begin
      obs_q.push_back('{digits_bcd, digit_blank, digit_err});
      last_fv_cyc = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: the bus is viewed as runs of identical {an_n,seg_n};
  // a run on a single low anode lasting at least S+1 cycles is captured once
  logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  int         m_bcd   [ND];
  bit         m_blank [ND];
  bit         m_err   [ND];
  bit [ND-1:0] m_seen;
  logic [3:0] cur_an  = 4'hf;
  logic [6:0] cur_seg = 7'h7f;
  int         cur_len = 0;

  task automatic model_decode(input logic [6:0] s, output int v, output bit b, output bit e);
    v = 0; b = 0; e = 1;
    if (s == 7'h7f) begin
      b = 1; e = 0;
    end else begin
      for (int k = 0; k < 10; k++) if (s == pat[k]) begin v = k; e = 0; end
    end
  endtask

  task automatic finalize();
    if (cur_len >= S + 1 && $countones(~cur_an) == 1) begin
      int i;
      frame_t f;
      i = 0;
      for (int k = 0; k < ND; k++) if (!cur_an[k]) i = k;
      model_decode(cur_seg, m_bcd[i], m_blank[i], m_err[i]);
      m_seen[i] = 1'b1;
      if (&m_seen) begin
        f.bcd = '0; f.blank = '0; f.err = '0;
        for (int k = 0; k < ND; k++) begin
          f.bcd   = f.bcd | (16'(m_bcd[k]) << (4 * k));
          f.blank[k] = m_blank[k];
          f.err[k]   = m_err[k];
        end
        exp_q.push_back(f);
        m_seen = '0;
      end
    end
    cur_len = 0;
  endtask

  task automatic model_reset();
    m_seen = '0;
    cur_len = 0;
    for (int k = 0; k < ND; k++) begin
      m_bcd[k] = 0; m_blank[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    if (a !== cur_an || s !== cur_seg) begin
      finalize();
      cur_an  = a;
      cur_seg = s;
    end
    an_n  = a;
    seg_n = s;
    cur_len += n;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic slot(input int d, input logic [6:0] s, input int n);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    drive(a, s, n);
  endtask

  task automatic checkpoint(input string tag, input logic exp_stale);
    int n;
    drive(4'hf, 7'h7f, S + 6);
    finalize();
    check_val({tag, "_nframes"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_val({tag, "_bcd"},   obs_q[i].bcd,   exp_q[i].bcd);
      check_val({tag, "_blank"}, obs_q[i].blank, exp_q[i].blank);
      check_val({tag, "_err"},   obs_q[i].err,   exp_q[i].err);
    end
    check_val({tag, "_stale"}, stale, exp_stale);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_bcd"},   digits_bcd,  16'h0000);
    check_val({tag, "_blank"}, digit_blank, 4'hf);
    check_val({tag, "_err"},   digit_err,   4'h0);
    check_val({tag, "_fv"},    frame_valid, 1'b0);
    check_val({tag, "_stale"}, stale,       1'b0);
  endtask

  task automatic do_reset();
    drive(4'hf, 7'h7f, 4);
    finalize();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int lat_start;
    logic [3:0] bad [4];
    logic [3:0] a;
    logic [6:0] s;
    int n, r;
    bad = '{4'b1111, 4'b0000, 4'b1100, 4'b0101};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("reset");

    // scan 1,2,3,4
    slot(0, pat[1], 20);
    slot(1, pat[2], 20);
    slot(2, pat[3], 20);
    lat_start = cyc;
    slot(3, pat[4], 20);
    checkpoint("scan1234", 1'b0);
    check_val("scan1234_out", digits_bcd, 16'h4321);
    check_val("scan1234_latency", last_fv_cyc - lat_start, S + 4);

    // last slot held one cycle too short
    slot(0, pat[6], 20);
    slot(1, pat[7], 20);
    slot(2, pat[8], 20);
    slot(3, pat[9], S - 1);
    drive(4'hf, 7'h7f, S + 6);
    check_val("short_noframe", obs_q.size(), 0);
    slot(3, pat[9], 20);
    checkpoint("short_resume", 1'b0);
    check_val("short_resume_out", digits_bcd, 16'h9876);

    // blank and error patterns
    slot(0, pat[5], 20);
    slot(1, pat[9], 20);
    slot(2, 7'b1111111, 20);
    slot(3, 7'b1110000, 20);
    checkpoint("blankerr", 1'b0);
    check_val("blankerr_bcd",   digits_bcd,  16'h0095);
    check_val("blankerr_blank", digit_blank, 4'b0100);
    check_val("blankerr_err",   digit_err,   4'b1000);

    // ghosting mid-scan
    slot(0, pat[7], 20);
    slot(1, pat[2], 20);
    drive(4'b1100, pat[3], 100);
    check_val("ghost_noframe", obs_q.size(), 0);
    slot(2, pat[0], 20);
    slot(3, pat[1], 20);
    checkpoint("ghost", 1'b0);

    // reset after two captures
    slot(0, pat[3], 20);
    slot(1, pat[4], 20);
    do_reset();
    check_reset_outputs("midreset");
    slot(2, pat[5], 20);
    slot(3, pat[6], 20);
    drive(4'hf, 7'h7f, S + 6);
    check_val("midreset_noframe", obs_q.size(), 0);
    slot(0, pat[2], 20);
    slot(1, pat[8], 20);
    slot(2, pat[5], 20);
    slot(3, pat[6], 20);
    checkpoint("midreset_full", 1'b0);

    // randomized bus activity
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 99) < 80) a = ~(4'b0001 << $urandom_range(0, 3));
      else                            a = bad[$urandom_range(0, 3)];
      r = $urandom_range(0, 99);
      if (r < 60)      s = pat[$urandom_range(0, 9)];
      else if (r < 75) s = 7'h7f;
      else             s = 7'($urandom);
      if ($urandom_range(0, 1) == 0) n = $urandom_range(1, S - 1);
      else                           n = $urandom_range(S + 3, S + 12);
      if (a === cur_an && s === cur_seg) s = s ^ 7'h01;
      drive(a, s, n);
    end
    for (int d = 0; d < ND; d++) slot(d, pat[$urandom_range(0, 9)], 20);
    checkpoint("random", 1'b0);

    // timeout
    slot(0, pat[5], 20);
    slot(1, pat[6], 20);
    slot(2, pat[7], 20);
    slot(3, pat[8], 20);
    checkpoint("stale_pre", 1'b0);
    drive(4'hf, 7'h7f, T - 100);
    check_val("stale_early", stale, 1'b0);
    drive(4'hf, 7'h7f, 200);
    check_val("stale_set", stale, 1'b1);
    slot(0, pat[1], 20);
    slot(1, pat[2], 20);
    slot(2, pat[3], 20);
    slot(3, pat[4], 20);
    checkpoint("stale_clear", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
